// File: rtl/spi_par_master_arbiter.sv
// -----------------------------------------------------------------------------
// spi_par_master_arbiter
//
// Master-side sequencer for a parallel (NB_BITS-wide) CPOL=0/CPHA=0 SPI slave
// link. Two requesters share the link. A round-robin arbiter picks one of them,
// and then exactly one word is exchanged for that grant:
//   SETUP   : chip select up, SCLK low (slave loads its reply word)
//   SCLK_HI : SCLK high, MISO captured on the last cycle of the phase
//   SCLK_LO : SCLK low again (falling edge, slave captures MOSI)
//   GAP     : chip select down, done pulse on the last cycle of the phase
// Each non-idle phase lasts exactly SCLK_HALF system clocks.
//
// Parameters
//   NB_BITS    width of the MOSI/MISO words and of the requester data
//   SCLK_HALF  system clocks per phase, must be >= 2
//
// Ports
//   i_clk      system clock, rising edge
//   i_rst      synchronous active-high reset
//   i_req      per-requester level request, held until o_done
//   i_wdata0   word to send for requester 0
//   i_wdata1   word to send for requester 1
//   o_gnt      one-hot grant, held for the whole transaction
//   o_done     one-cycle pulse to the granted requester, o_rdata valid
//   o_rdata    last word captured from MISO
//   o_busy     high whenever the sequencer is not idle
//   o_cs       slave chip select, active-high
//   o_SCLK     serial clock, idle low
//   o_MOSI     word driven to the slave
//   i_MISO     word returned by the slave
// -----------------------------------------------------------------------------
module spi_par_master_arbiter #(
    parameter int NB_BITS   = 32,
    parameter int SCLK_HALF = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [1:0]         i_req,
    input  logic [NB_BITS-1:0] i_wdata0,
    input  logic [NB_BITS-1:0] i_wdata1,
    output logic [1:0]         o_gnt,
    output logic [1:0]         o_done,
    output logic [NB_BITS-1:0] o_rdata,
    output logic               o_busy,
    output logic               o_cs,
    output logic               o_SCLK,
    output logic [NB_BITS-1:0] o_MOSI,
    input  logic [NB_BITS-1:0] i_MISO
);

    // Phase counter runs SCLK_HALF-1 down to 0 in every non-idle state.
    localparam int CNT_W = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCLK_HALF - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SCLK_HI,
        ST_SCLK_LO,
        ST_GAP
    } state_t;

    state_t               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 prio_q;     // 1: requester 1 wins a tie
    logic [1:0]           gnt_q;
    logic [1:0]           done_q;
    logic [NB_BITS-1:0]   rdata_q;
    logic [NB_BITS-1:0]   mosi_q;
    logic                 cs_q;
    logic                 sclk_q;

    // Arbitration result, only acted upon while idle.
    logic [1:0]           win_gnt_d;
    logic [NB_BITS-1:0]   win_wdata_d;
    logic                 phase_last;

    assign phase_last = (cnt_q == CNT_ZERO);

    // Round robin: a lone request wins outright; on a tie the requester that
    // was not served last wins.
    always_comb begin
        win_gnt_d = 2'b00;
        case (i_req)
            2'b01:   win_gnt_d = 2'b01;
            2'b10:   win_gnt_d = 2'b10;
            2'b11:   win_gnt_d = prio_q ? 2'b10 : 2'b01;
            default: win_gnt_d = 2'b00;
        endcase
        win_wdata_d = win_gnt_d[1] ? i_wdata1 : i_wdata0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
            prio_q  <= 1'b0;
            gnt_q   <= 2'b00;
            done_q  <= 2'b00;
            rdata_q <= '0;
            mosi_q  <= '0;
            cs_q    <= 1'b0;
            sclk_q  <= 1'b0;
        end else begin
            done_q <= 2'b00;
            case (state_q)
                ST_IDLE: begin
                    if (win_gnt_d != 2'b00) begin
                        state_q <= ST_SETUP;
                        cnt_q   <= CNT_LAST;
                        gnt_q   <= win_gnt_d;
                        mosi_q  <= win_wdata_d;   // later wdata changes are ignored
                        cs_q    <= 1'b1;
                        // The other requester gets the next tie.
                        prio_q  <= ~win_gnt_d[1];
                    end
                end

                ST_SETUP: begin
                    if (phase_last) begin
                        state_q <= ST_SCLK_HI;
                        cnt_q   <= CNT_LAST;
                        sclk_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end

                ST_SCLK_HI: begin
                    if (phase_last) begin
                        state_q <= ST_SCLK_LO;
                        cnt_q   <= CNT_LAST;
                        sclk_q  <= 1'b0;
                        rdata_q <= i_MISO;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end

                ST_SCLK_LO: begin
                    if (phase_last) begin
                        state_q <= ST_GAP;
                        cnt_q   <= CNT_LAST;
                        cs_q    <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end

                ST_GAP: begin
                    // done is registered, so it is launched one cycle early
                    // to be visible during the final GAP cycle.
                    if (cnt_q == CNT_ONE) begin
                        done_q <= gnt_q;
                    end
                    if (phase_last) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= CNT_ZERO;
                        gnt_q   <= 2'b00;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= CNT_ZERO;
                    gnt_q   <= 2'b00;
                    cs_q    <= 1'b0;
                    sclk_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_gnt   = gnt_q;
    assign o_done  = done_q;
    assign o_rdata = rdata_q;
    assign o_busy  = (state_q != ST_IDLE);
    assign o_cs    = cs_q;
    assign o_SCLK  = sclk_q;
    assign o_MOSI  = mosi_q;

endmodule

// File: tb/tb_spi_par_master_arbiter.sv
// -----------------------------------------------------------------------------
// tb_spi_par_master_arbiter
//
// Table-driven bench for spi_par_master_arbiter. Instance A runs with
// SCLK_HALF=2, instance B with SCLK_HALF=5. Each transaction is checked cycle
// by cycle against a profile computed from the transaction start, plus the
// received/returned words of a small slave model.
// -----------------------------------------------------------------------------
module tb_spi_par_master_arbiter;

    localparam int SHA = 2;
    localparam int SHB = 5;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    // Instance A signals
    logic [1:0]  a_req;
    logic [31:0] a_w0, a_w1, a_miso, a_miso_val, a_mosi, a_rdata, a_rx;
    logic [1:0]  a_gnt, a_done;
    logic        a_busy, a_cs, a_sclk, a_echo;

    // Instance B signals
    logic [1:0]  b_req;
    logic [31:0] b_w0, b_w1, b_miso, b_mosi, b_rdata, b_rx;
    logic [1:0]  b_gnt, b_done;
    logic        b_busy, b_cs, b_sclk;

    int checks = 0;
    int errors = 0;

    spi_par_master_arbiter #(.NB_BITS(32), .SCLK_HALF(SHA)) dut_a (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_req    (a_req),
        .i_wdata0 (a_w0),
        .i_wdata1 (a_w1),
        .o_gnt    (a_gnt),
        .o_done   (a_done),
        .o_rdata  (a_rdata),
        .o_busy   (a_busy),
        .o_cs     (a_cs),
        .o_SCLK   (a_sclk),
        .o_MOSI   (a_mosi),
        .i_MISO   (a_miso)
    );

    spi_par_master_arbiter #(.NB_BITS(32), .SCLK_HALF(SHB)) dut_b (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_req    (b_req),
        .i_wdata0 (b_w0),
        .i_wdata1 (b_w1),
        .o_gnt    (b_gnt),
        .o_done   (b_done),
        .o_rdata  (b_rdata),
        .o_busy   (b_busy),
        .o_cs     (b_cs),
        .o_SCLK   (b_sclk),
        .o_MOSI   (b_mosi),
        .i_MISO   (b_miso)
    );

    // Slave models: reply word either fixed or an echo of MOSI; MOSI is
    // captured on the falling SCLK edge.
    assign a_miso = a_echo ? a_mosi : a_miso_val;
    always @(negedge a_sclk) a_rx = a_mosi;
    always @(negedge b_sclk) b_rx = b_mosi;

    typedef struct {
        logic [1:0]  req;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] miso;
        logic        echo;
        logic        hold;
        logic [1:0]  gnt;
        logic [31:0] rdata;
        logic [31:0] rx;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected {cs, sclk, busy, gnt[1:0], done[1:0]} during cycle n after the
    // edge that started the transaction (n=1 is the first SETUP cycle).
    function automatic logic [6:0] prof(input int n, input int sh, input logic [1:0] g);
        logic       cs, sclk, busy;
        logic [1:0] gg, dd;
        cs   = (n >= 1) && (n <= 3 * sh);
        sclk = (n > sh) && (n <= 2 * sh);
        busy = (n >= 1) && (n <= 4 * sh);
        gg   = busy ? g : 2'b00;
        dd   = (n == 4 * sh) ? g : 2'b00;
        return {cs, sclk, busy, gg, dd};
    endfunction

    // One transaction on instance A, entered and left in an IDLE cycle.
    task automatic run_a(input string tag, input logic [1:0] req,
                         input logic [31:0] w0, input logic [31:0] w1,
                         input logic [31:0] miso, input logic echo, input logic hold,
                         input logic [1:0] eg, input logic [31:0] erd, input logic [31:0] erx);
        a_req      = req;
        a_w0       = w0;
        a_w1       = w1;
        a_miso_val = miso;
        a_echo     = echo;
        for (int n = 1; n <= 4 * SHA + 1; n++) begin
            @(posedge clk); #1;
            chk($sformatf("%s profile n=%0d", tag, n),
                {a_cs, a_sclk, a_busy, a_gnt, a_done}, prof(n, SHA, eg));
            if (n == 4 * SHA && !hold) a_req = 2'b00;
        end
        chk({tag, " rdata"}, a_rdata, erd);
        chk({tag, " slave_rx"}, a_rx, erx);
        chk({tag, " mosi"}, a_mosi, erx);
        $display("txn %s req=%b gnt_exp=%b rdata=%h rx=%h", tag, req, eg, a_rdata, a_rx);
    endtask

    initial begin
        int done_cnt;
        logic [1:0] done_or;

        //                 req    w0            w1            miso          echo  hold  gnt    rdata         rx
        vecs[0] = '{2'b11, 32'h0000000A, 32'h0000000B, 32'h0,        1'b1, 1'b1, 2'b01, 32'h0000000A, 32'h0000000A};
        vecs[1] = '{2'b11, 32'h0000000A, 32'h0000000B, 32'h0,        1'b1, 1'b1, 2'b10, 32'h0000000B, 32'h0000000B};
        vecs[2] = '{2'b11, 32'h0000000A, 32'h0000000B, 32'h0,        1'b1, 1'b0, 2'b01, 32'h0000000A, 32'h0000000A};
        vecs[3] = '{2'b01, 32'hDEADBEEF, 32'h0,        32'h12345678, 1'b0, 1'b0, 2'b01, 32'h12345678, 32'hDEADBEEF};
        vecs[4] = '{2'b10, 32'h0,        32'hCAFEF00D, 32'h0F0F0F0F, 1'b0, 1'b0, 2'b10, 32'h0F0F0F0F, 32'hCAFEF00D};
        vecs[5] = '{2'b11, 32'h11111111, 32'h22222222, 32'h0,        1'b1, 1'b0, 2'b01, 32'h11111111, 32'h11111111};
        vecs[6] = '{2'b10, 32'h0,        32'h80000001, 32'hFFFFFFFF, 1'b0, 1'b0, 2'b10, 32'hFFFFFFFF, 32'h80000001};
        vecs[7] = '{2'b01, 32'h00000001, 32'h0,        32'h00000000, 1'b0, 1'b0, 2'b01, 32'h00000000, 32'h00000001};

        rst = 1'b1;
        a_req = 2'b00; a_w0 = '0; a_w1 = '0; a_miso_val = '0; a_echo = 1'b0;
        b_req = 2'b00; b_w0 = '0; b_w1 = '0; b_miso = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset A outputs", {a_cs, a_sclk, a_busy, a_gnt, a_done}, 7'd0);
        chk("reset A rdata", a_rdata, 32'h0);
        chk("reset A mosi", a_mosi, 32'h0);
        chk("reset B outputs", {b_cs, b_sclk, b_busy, b_gnt, b_done}, 7'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Table: arbitration alternation with held requests, single requests,
        // boundary data words.
        for (int i = 0; i < 8; i++) begin
            run_a($sformatf("vec%0d", i), vecs[i].req, vecs[i].w0, vecs[i].w1,
                  vecs[i].miso, vecs[i].echo, vecs[i].hold,
                  vecs[i].gnt, vecs[i].rdata, vecs[i].rx);
        end

        // Requester 1 held continuously: back-to-back with one IDLE cycle.
        run_a("b2b0", 2'b10, 32'h0, 32'h5A5A5A5A, 32'h3C3C3C3C, 1'b0, 1'b1, 2'b10, 32'h3C3C3C3C, 32'h5A5A5A5A);
        run_a("b2b1", 2'b10, 32'h0, 32'h5A5A5A5A, 32'h3C3C3C3C, 1'b0, 1'b1, 2'b10, 32'h3C3C3C3C, 32'h5A5A5A5A);
        run_a("b2b2", 2'b10, 32'h0, 32'h5A5A5A5A, 32'h3C3C3C3C, 1'b0, 1'b0, 2'b10, 32'h3C3C3C3C, 32'h5A5A5A5A);

        // Reset during SCLK_HI, then tie must go to requester 0.
        a_req = 2'b01; a_w0 = 32'h77777777; a_miso_val = 32'h88888888; a_echo = 1'b0;
        @(posedge clk); #1;
        repeat (SHA) begin
            @(posedge clk); #1;
        end
        chk("rst_mid sclk_hi", a_sclk, 1'b1);
        rst = 1'b1;
        a_req = 2'b00;
        @(posedge clk); #1;
        chk("rst_mid outputs", {a_cs, a_sclk, a_busy, a_gnt, a_done}, 7'd0);
        chk("rst_mid rdata", a_rdata, 32'h0);
        rst = 1'b0;
        done_cnt = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (a_done != 2'b00) done_cnt++;
        end
        chk("rst_mid no done", done_cnt, 0);
        run_a("rst_rr", 2'b11, 32'h44444444, 32'h55555555, 32'h99999999, 1'b0, 1'b0, 2'b01, 32'h99999999, 32'h44444444);

        // Request dropped in SETUP, wdata changed in SCLK_LO.
        a_req = 2'b01; a_w0 = 32'h13579BDF; a_miso_val = 32'hABCDEF01; a_echo = 1'b0;
        done_cnt = 0;
        done_or  = 2'b00;
        for (int n = 1; n <= 4 * SHA + 3; n++) begin
            @(posedge clk); #1;
            if (n == 1) a_req = 2'b00;
            if (n == 2 * SHA + 1) a_w0 = 32'h00000000;
            if (a_done != 2'b00) begin
                done_cnt++;
                done_or = done_or | a_done;
            end
        end
        chk("drop done count", done_cnt, 1);
        chk("drop done value", done_or, 2'b01);
        chk("drop slave_rx", a_rx, 32'h13579BDF);
        chk("drop mosi", a_mosi, 32'h13579BDF);
        chk("drop rdata", a_rdata, 32'hABCDEF01);
        chk("drop idle", a_busy, 1'b0);
        $display("txn drop req=01 done_cnt=%0d rdata=%h rx=%h", done_cnt, a_rdata, a_rx);

        // SCLK_HALF=5 instance, single request.
        b_req = 2'b01; b_w0 = 32'h0BADF00D; b_miso = 32'h600DF00D;
        for (int n = 1; n <= 4 * SHB + 1; n++) begin
            @(posedge clk); #1;
            chk($sformatf("sh5 profile n=%0d", n),
                {b_cs, b_sclk, b_busy, b_gnt, b_done}, prof(n, SHB, 2'b01));
            if (n == 4 * SHB) b_req = 2'b00;
        end
        chk("sh5 rdata", b_rdata, 32'h600DF00D);
        chk("sh5 slave_rx", b_rx, 32'h0BADF00D);
        $display("txn sh5 req=01 rdata=%h rx=%h", b_rdata, b_rx);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
